// File: rtl/pc_ir_unit.sv
// Program counter, instruction register and datapath holding registers for a
// multi-cycle CPU: PC update/branch resolution, fetch address mux, field decode.
module pc_ir_unit #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_write,
    input  logic         pc_src,
    input  logic         ior_d,
    input  logic         ir_write,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero,
    input  logic [W-1:0] mem_rdata,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] pc,
    output logic [W-1:0] ir,
    output logic [3:0]   opcode,
    output logic [3:0]   rd,
    output logic [3:0]   rs,
    output logic [3:0]   rt,
    output logic [W-1:0] imm_ext,
    output logic [W-1:0] mdr,
    output logic [W-1:0] alu_out,
    output logic         branch_taken,
    output logic [15:0]  instr_count
);

    logic [W-1:0] pc_reg, pc_next;
    logic [W-1:0] ir_reg;
    logic [W-1:0] mdr_reg;
    logic [W-1:0] alu_out_reg;
    logic [15:0]  count_reg;

    assign pc          = pc_reg;
    assign ir          = ir_reg;
    assign mdr         = mdr_reg;
    assign alu_out     = alu_out_reg;
    assign instr_count = count_reg;

    assign opcode = ir_reg[W-1:W-4];
    assign rd     = ir_reg[11:8];
    assign rs     = ir_reg[7:4];
    assign rt     = ir_reg[3:0];

    assign mem_addr = ior_d ? alu_out_reg : pc_reg;

    always_comb begin
        branch_taken = 1'b0;
        case (opcode)
            4'b0100: branch_taken = alu_zero;
            4'b0101: branch_taken = ~alu_zero;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        imm_ext = '0;
        case (opcode)
            4'b1001, 4'b1101, 4'b0001, 4'b0010, 4'b0100, 4'b0101:
                imm_ext = {{(W-4){ir_reg[3]}}, ir_reg[3:0]};
            4'b1010, 4'b1110, 4'b0111, 4'b0110, 4'b0000:
                imm_ext = {{(W-4){1'b0}}, ir_reg[3:0]};
            4'b0011:
                imm_ext = {{(W-12){ir_reg[11]}}, ir_reg[11:0]};
            default:
                imm_ext = '0;
        endcase
    end

    // Branch target comes from alu_out, computed by the ALU in an earlier cycle.
    always_comb begin
        pc_next = pc_reg;
        if (pc_write) begin
            if (!pc_src) begin
                pc_next = alu_result;
            end else if (branch_taken) begin
                pc_next = alu_out_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg      <= '0;
            ir_reg      <= '0;
            mdr_reg     <= '0;
            alu_out_reg <= '0;
            count_reg   <= '0;
        end else begin
            pc_reg      <= pc_next;
            alu_out_reg <= alu_result;
            mdr_reg     <= mem_rdata;
            if (ir_write) begin
                ir_reg    <= mem_rdata;
                count_reg <= count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed vectors plus randomized cycles
// compared against an instruction-level reference model.
module tb_pc_ir_unit;

    logic        clk;
    logic        rst;
    logic        pc_write, pc_src, ior_d, ir_write;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr, pc, ir, imm_ext, mdr, alu_out, instr_count;
    logic [3:0]  opcode, rd, rs, rt;
    logic        branch_taken;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    // Reference state: architectural registers as plain numbers
    int m_pc, m_ir, m_mdr, m_alu_out, m_cnt;

    pc_ir_unit #(.W(16)) dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .pc_src(pc_src),
        .ior_d(ior_d), .ir_write(ir_write), .alu_result(alu_result),
        .alu_zero(alu_zero), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .pc(pc), .ir(ir), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
        .imm_ext(imm_ext), .mdr(mdr), .alu_out(alu_out),
        .branch_taken(branch_taken), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int model_imm(input int ir_v);
        int op, lo, j;
        op = ir_v / 4096;
        lo = ir_v % 16;
        j  = ir_v % 4096;
        case (op)
            9, 13, 1, 2, 4, 5: return (lo >= 8) ? lo + 65536 - 16 : lo;
            10, 14, 7, 6, 0:   return lo;
            3:                 return (j >= 2048) ? j + 65536 - 4096 : j;
            default:           return 0;
        endcase
    endfunction

    function automatic int model_bt(input int ir_v, input logic az);
        case (ir_v / 4096)
            4:       return az ? 1 : 0;
            5:       return az ? 0 : 1;
            default: return 0;
        endcase
    endfunction

    task automatic check_all();
        int exp_addr;
        exp_addr = ior_d ? m_alu_out : m_pc;
        check("mem_addr", mem_addr, 16'(exp_addr));
        check("pc", pc, 16'(m_pc));
        check("ir", ir, 16'(m_ir));
        check("mdr", mdr, 16'(m_mdr));
        check("alu_out", alu_out, 16'(m_alu_out));
        check("instr_count", instr_count, 16'(m_cnt));
        check("opcode", {12'd0, opcode}, 16'(m_ir / 4096));
        check("rd", {12'd0, rd}, 16'((m_ir / 256) % 16));
        check("rs", {12'd0, rs}, 16'((m_ir / 16) % 16));
        check("rt", {12'd0, rt}, 16'(m_ir % 16));
        check("imm_ext", imm_ext, 16'(model_imm(m_ir)));
        check("branch_taken", {15'd0, branch_taken}, 16'(model_bt(m_ir, alu_zero)));
    endtask

    // One clock: drive at negedge, check combinational/registered view, clock, advance model.
    task automatic step(input logic r, input logic pcw, input logic psrc, input logic iord,
                        input logic irw, input logic [15:0] ar, input logic az,
                        input logic [15:0] md, input bit quiet);
        int npc, bt;
        @(negedge clk);
        rst = r; pc_write = pcw; pc_src = psrc; ior_d = iord; ir_write = irw;
        alu_result = ar; alu_zero = az; mem_rdata = md;
        #1;
        check_all();
        n_txn++;
        if (!quiet)
            $display("[TB] txn %0d rst=%0b pcw=%0b src=%0b iord=%0b irw=%0b ar=%h az=%0b md=%h pc=%h ir=%h",
                     n_txn, r, pcw, psrc, iord, irw, ar, az, md, pc, ir);
        @(posedge clk);
        if (r) begin
            m_pc = 0; m_ir = 0; m_mdr = 0; m_alu_out = 0; m_cnt = 0;
        end else begin
            bt  = model_bt(m_ir, az);
            npc = m_pc;
            if (pcw) begin
                if (!psrc)        npc = ar;
                else if (bt != 0) npc = m_alu_out;
            end
            if (irw) begin
                m_ir  = md;
                m_cnt = (m_cnt + 1) % 65536;
            end
            m_alu_out = ar;
            m_mdr     = md;
            m_pc      = npc;
        end
    endtask

    initial begin
        rst = 1'b1; pc_write = 1'b1; pc_src = 1'b0; ior_d = 1'b0; ir_write = 1'b1;
        alu_result = 16'h1234; alu_zero = 1'b0; mem_rdata = 16'h5678;
        repeat (2) @(posedge clk);
        m_pc = 0; m_ir = 0; m_mdr = 0; m_alu_out = 0; m_cnt = 0;

        // Reset state, including decoded fields
        step(1, 1, 1, 0, 1, 16'hAAAA, 1, 16'h4444, 0);
        #1;
        check("rst_pc", pc, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_imm", imm_ext, 16'h0000);

        // Fetch
        step(0, 1, 0, 0, 1, 16'h0001, 0, 16'h8123, 0);
        #1;
        check("fetch_pc", pc, 16'h0001);
        check("fetch_ir", ir, 16'h8123);
        check("fetch_op", {12'd0, opcode}, 16'h0008);
        check("fetch_fields", {4'd0, rd, rs, rt}, 16'h0123);
        check("fetch_cnt", instr_count, 16'h0001);
        check("r_type_imm", imm_ext, 16'h0000);

        // BEQ taken then not taken
        step(0, 0, 0, 0, 1, 16'h0010, 0, 16'h4127, 0);
        step(0, 1, 1, 0, 0, 16'h0010, 1, 16'h0000, 0);
        #1 check("beq_taken_pc", pc, 16'h0010);
        step(0, 0, 0, 0, 0, 16'h0020, 0, 16'h0000, 0);
        step(0, 1, 1, 0, 0, 16'h0030, 0, 16'h0000, 0);
        #1 check("beq_not_taken_pc", pc, 16'h0010);

        // BNE taken then not taken
        step(0, 0, 0, 0, 1, 16'h0050, 0, 16'h5127, 0);
        step(0, 1, 1, 0, 0, 16'h0060, 0, 16'h0000, 0);
        #1 check("bne_taken_pc", pc, 16'h0050);
        step(0, 1, 1, 0, 0, 16'h0070, 1, 16'h0000, 0);
        #1 check("bne_not_taken_pc", pc, 16'h0050);

        // Immediates
        step(0, 0, 0, 0, 1, 16'h0000, 0, 16'h912F, 0);
        #1 check("imm_sext4", imm_ext, 16'hFFFF);
        step(0, 0, 0, 0, 1, 16'h0000, 0, 16'hA12F, 0);
        #1 check("imm_zext4", imm_ext, 16'h000F);
        step(0, 0, 0, 0, 1, 16'h0000, 0, 16'h3800, 0);
        #1 check("imm_jump", imm_ext, 16'hF800);

        // Load address path: alu_out drives the address, ir holds
        step(0, 0, 0, 0, 0, 16'h0042, 0, 16'h0000, 0);
        step(0, 0, 0, 1, 0, 16'h0000, 0, 16'hBEEF, 0);
        #1;
        check("load_mdr", mdr, 16'hBEEF);
        check("load_ir_hold", ir, 16'h3800);

        // Counter wrap
        while (m_cnt != 65535) step(0, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 1);
        #1 check("cnt_max", instr_count, 16'hFFFF);
        step(0, 0, 0, 0, 1, 16'h0000, 0, 16'h1234, 0);
        #1 check("cnt_wrap", instr_count, 16'h0000);

        // Reset overriding a fetch
        step(0, 1, 0, 0, 1, 16'h7777, 0, 16'h4321, 0);
        step(1, 1, 0, 0, 1, 16'h9999, 1, 16'h5555, 0);
        #1;
        check("rst_mid_pc", pc, 16'h0000);
        check("rst_mid_ir", ir, 16'h0000);
        check("rst_mid_mdr", mdr, 16'h0000);
        check("rst_mid_alu_out", alu_out, 16'h0000);
        check("rst_mid_cnt", instr_count, 16'h0000);

        // Randomized cycles; opcodes biased toward branches
        for (int i = 0; i < 400; i++) begin
            logic [15:0] md;
            md = 16'($urandom);
            if ($urandom_range(0, 2) == 0) md[15:12] = ($urandom_range(0, 1) == 0) ? 4'h4 : 4'h5;
            step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 16'($urandom), 1'($urandom), md, 0);
        end
        @(negedge clk);
        #1 check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
